// File: rtl/bcd_counter_n.sv
// Registered N-digit packed-BCD counter with clear, checked load and wrap/saturate modes.
// Define BCD_COUNTER_DOWN_EN to enable down-counting on dec and the borrow pulse.
module bcd_counter_n #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                inc,
  input  logic                dec,
  output logic [4*DIGITS-1:0] count,
  output logic                carry,
  output logic                borrow,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    count_q, count_d;
  logic            carry_q, carry_d;
  logic            borrow_q, borrow_d;
  logic            load_err_q, load_err_d;

  logic [W-1:0]    up_val, dn_val;
  logic [DIGITS:0] run9, run0;
  logic            all9, all0;
  logic            load_ok;
  logic            step_up, step_dn;

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // run9[i] / run0[i]: every digit below i is 9 / 0, so digit i takes the step.
  always_comb begin
    run9    = '0;
    run0    = '0;
    run9[0] = 1'b1;
    run0[0] = 1'b1;
    up_val  = count_q;
    dn_val  = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      run9[i+1] = run9[i] & (count_q[4*i +: 4] == 4'd9);
      run0[i+1] = run0[i] & (count_q[4*i +: 4] == 4'd0);
      if (run9[i]) begin
        up_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
      end
      if (run0[i]) begin
        dn_val[4*i +: 4] = (count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1;
      end
    end
  end

  assign all9 = run9[DIGITS];
  assign all0 = run0[DIGITS];

`ifdef BCD_COUNTER_DOWN_EN
  assign step_up = inc & ~dec;
  assign step_dn = dec & ~inc;
`else
  logic unused_dn;
  assign step_up   = inc;
  assign step_dn   = 1'b0;
  assign unused_dn = ^{dec, dn_val, all0};
`endif

  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) count_d    = load_val;
      else         load_err_d = 1'b1;
    end else if (step_up) begin
      carry_d = all9;
      if (!all9 || WRAP) count_d = up_val;
    end else if (step_dn) begin
      borrow_d = all0;
      if (!all0 || WRAP) count_d = dn_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: four instances (2-digit wrap, 2-digit saturate, 4-digit, 1-digit)
// driven from shared controls; expected responses are queued and checked by a monitor.
module tb_bcd_counter_n;

  localparam int EW = 21;  // {id[1:0], count[15:0], carry, borrow, load_err}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, load, inc, dec;
  logic [7:0]  lv2;
  logic [15:0] lv4;

  logic [7:0]  cnt_a, cnt_b;
  logic [15:0] cnt_c;
  logic [3:0]  cnt_d;
  logic        carry_a, borrow_a, lerr_a;
  logic        carry_b, borrow_b, lerr_b;
  logic        carry_c, borrow_c, lerr_c;
  logic        carry_d, borrow_d, lerr_d;

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv2), .inc(inc), .dec(dec),
    .count(cnt_a), .carry(carry_a), .borrow(borrow_a), .load_err(lerr_a));
  bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv2), .inc(inc), .dec(dec),
    .count(cnt_b), .carry(carry_b), .borrow(borrow_b), .load_err(lerr_b));
  bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv4), .inc(inc), .dec(dec),
    .count(cnt_c), .carry(carry_c), .borrow(borrow_c), .load_err(lerr_c));
  bcd_counter_n #(.DIGITS(1), .WRAP(1'b1)) u_d (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv2[3:0]), .inc(inc), .dec(dec),
    .count(cnt_d), .carry(carry_d), .borrow(borrow_d), .load_err(lerr_d));

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e, mon_act;
  int checks = 0;
  int errors = 0;
  int carry_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic [1:0] id, input logic [15:0] cnt,
                                        input logic c, input logic b, input logic l);
    return {id, cnt, c, b, l};
  endfunction

  function automatic logic [15:0] to_bcd(input int m);
    return {4'((m / 1000) % 10), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Drive one cycle of controls and queue the response expected after that edge.
  task automatic step(input logic s_clr, input logic s_load, input logic s_inc, input logic s_dec,
                      input logic [15:0] v, input logic [EW-1:0] e);
    @(negedge clk);
    clr  = s_clr;
    load = s_load;
    inc  = s_inc;
    dec  = s_dec;
    lv2  = v[7:0];
    lv4  = v;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      case (mon_e[20:19])
        2'd0:    mon_act = {2'd0, 8'h00, cnt_a, carry_a, borrow_a, lerr_a};
        2'd1:    mon_act = {2'd1, 8'h00, cnt_b, carry_b, borrow_b, lerr_b};
        2'd2:    mon_act = {2'd2, cnt_c, carry_c, borrow_c, lerr_c};
        default: mon_act = {2'd3, 12'h000, cnt_d, carry_d, borrow_d, lerr_d};
      endcase
      if (mon_e[20:19] == 2'd2 && carry_c) carry_seen++;
      check($sformatf("dut%0d_out", mon_e[20:19]), 32'(mon_act), 32'(mon_e));
    end
  end

  initial begin
    int m, nm;
    rst = 1'b1; clr = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0; lv2 = '0; lv4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", 32'({cnt_a, carry_a, borrow_a, lerr_a}), 32'h0);
    check("reset_b", 32'({cnt_b, carry_b, borrow_b, lerr_b}), 32'h0);
    check("reset_c", 32'({cnt_c, carry_c, borrow_c, lerr_c}), 32'h0);
    check("reset_d", 32'({cnt_d, carry_d, borrow_d, lerr_d}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-count while a load_err pulse is showing.
    step(0, 1, 0, 0, 16'h0037, ent(0, 16'h0037, 0, 0, 0));
    step(0, 1, 0, 0, 16'h003A, ent(0, 16'h0037, 0, 0, 1));
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 32'({cnt_a, carry_a, borrow_a, lerr_a}), 32'h0);
    inc = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold", 32'({cnt_a, carry_a, borrow_a, lerr_a}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1, 0, 16'h0000, ent(0, 16'h0001, 0, 0, 0));

    // Wrap through all 9s.
    step(0, 1, 0, 0, 16'h0098, ent(0, 16'h0098, 0, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(0, 16'h0099, 0, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(0, 16'h0000, 1, 0, 0));
    step(0, 0, 0, 0, 16'h0000, ent(0, 16'h0000, 0, 0, 0));
    step(0, 1, 0, 0, 16'h0019, ent(0, 16'h0019, 0, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(0, 16'h0020, 0, 0, 0));

    // Saturating instance holds at 99 with a carry per edge.
    step(0, 1, 0, 0, 16'h0098, ent(1, 16'h0098, 0, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(1, 16'h0099, 0, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(1, 16'h0099, 1, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(1, 16'h0099, 1, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(1, 16'h0099, 1, 0, 0));
    step(0, 0, 0, 0, 16'h0000, ent(1, 16'h0099, 0, 0, 0));

    // Rejected loads and clear priority.
    step(0, 1, 0, 0, 16'h0025, ent(0, 16'h0025, 0, 0, 0));
    step(0, 1, 0, 0, 16'h003A, ent(0, 16'h0025, 0, 0, 1));
    step(0, 1, 0, 0, 16'h00A0, ent(0, 16'h0025, 0, 0, 1));
    step(0, 0, 0, 0, 16'h0000, ent(0, 16'h0025, 0, 0, 0));
    step(1, 1, 0, 0, 16'h003A, ent(0, 16'h0000, 0, 0, 0));
    step(0, 1, 0, 0, 16'h0047, ent(0, 16'h0047, 0, 0, 0));
    step(1, 1, 1, 0, 16'h0055, ent(0, 16'h0000, 0, 0, 0));
    step(0, 1, 1, 0, 16'h0042, ent(0, 16'h0042, 0, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(0, 16'h0043, 0, 0, 0));

`ifdef BCD_COUNTER_DOWN_EN
    step(0, 1, 0, 0, 16'h0010, ent(0, 16'h0010, 0, 0, 0));
    step(0, 0, 0, 1, 16'h0000, ent(0, 16'h0009, 0, 0, 0));
    step(0, 0, 0, 1, 16'h0000, ent(0, 16'h0008, 0, 0, 0));
    step(0, 1, 0, 0, 16'h0000, ent(0, 16'h0000, 0, 0, 0));
    step(0, 0, 0, 1, 16'h0000, ent(0, 16'h0099, 0, 1, 0));
    step(0, 0, 1, 1, 16'h0000, ent(0, 16'h0099, 0, 0, 0));
    step(0, 1, 0, 0, 16'h0000, ent(1, 16'h0000, 0, 0, 0));
    step(0, 0, 0, 1, 16'h0000, ent(1, 16'h0000, 0, 1, 0));
    step(0, 0, 0, 1, 16'h0000, ent(1, 16'h0000, 0, 1, 0));
`else
    step(0, 1, 0, 0, 16'h0010, ent(0, 16'h0010, 0, 0, 0));
    step(0, 0, 0, 1, 16'h0000, ent(0, 16'h0010, 0, 0, 0));
    step(0, 0, 1, 1, 16'h0000, ent(0, 16'h0011, 0, 0, 0));
    step(0, 1, 0, 0, 16'h0099, ent(0, 16'h0099, 0, 0, 0));
    step(0, 0, 1, 1, 16'h0000, ent(0, 16'h0000, 1, 0, 0));
    step(0, 1, 0, 0, 16'h0000, ent(1, 16'h0000, 0, 0, 0));
    step(0, 0, 0, 1, 16'h0000, ent(1, 16'h0000, 0, 0, 0));
`endif

    // Single-digit instance.
    step(0, 1, 0, 0, 16'h0008, ent(3, 16'h0008, 0, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(3, 16'h0009, 0, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(3, 16'h0000, 1, 0, 0));
    step(0, 0, 1, 0, 16'h0000, ent(3, 16'h0001, 0, 0, 0));
    step(0, 1, 0, 0, 16'h000C, ent(3, 16'h0001, 0, 0, 1));

    // Four digits: full decade cycle against a decimal model.
    step(1, 0, 0, 0, 16'h0000, ent(2, 16'h0000, 0, 0, 0));
    carry_seen = 0;
    m = 0;
    for (int k = 0; k < 10000; k++) begin
      nm = (m == 9999) ? 0 : m + 1;
      step(0, 0, 1, 0, 16'h0000, ent(2, to_bcd(nm), (m == 9999), 0, 0));
      m = nm;
    end
    step(0, 0, 0, 0, 16'h0000, ent(2, to_bcd(m), 0, 0, 0));
    #2;
    check("c_final", 32'(cnt_c), 32'h0);
    check("c_carry_count", 32'(carry_seen), 32'd1);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
